// File: rtl/b3_pkg.sv
// Shared base-3 digit definitions: the code constants and digit helpers.
// Used by the base-3 up and down counters.
package b3_pkg;

  localparam logic [1:0] B3_ZERO = 2'b00;
  localparam logic [1:0] B3_ONE  = 2'b01;
  localparam logic [1:0] B3_TWO  = 2'b10;
  localparam logic [1:0] B3_BAD  = 2'b11;

  // Map the unused code 11 to 10 so that 11 can never be stored.
  function automatic logic [1:0] b3_coerce(input logic [1:0] code);
    return (code == B3_BAD) ? B3_TWO : code;
  endfunction

  // Take one base-3 step down: 10->01, 01->00, and 00->10 with a borrow.
  // An 11 input cannot be stored, but it is treated as 10 for safety.
  function automatic logic [1:0] b3_dec(input logic [1:0] code);
    logic [1:0] result;
    case (code)
      B3_TWO:  result = B3_ONE;
      B3_ONE:  result = B3_ZERO;
      B3_ZERO: result = B3_TWO;
      default: result = B3_ONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/b3_down_digit.sv
// One base-3 down-counting digit register.
// Priority at the clock edge is load, then step down when en=1, then hold.
module b3_down_digit
  import b3_pkg::*;
(
  input  logic       clock,
  input  logic       reset_,
  input  logic [1:0] reset_value,
  input  logic       load,
  input  logic [1:0] d,
  input  logic       en,
  output logic [1:0] q,
  output logic       is_zero
);

  // Digit state: asynchronous reset to the coerced reset pattern.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q <= b3_coerce(reset_value);
    end else if (load) begin
      q <= b3_coerce(d);
    end else if (en) begin
      q <= b3_dec(q);
    end
  end

  assign is_zero = (q == B3_ZERO);

endmodule

// File: rtl/n4_b3_down_counter.sv
// Four-digit base-3 down counter with a synchronous parallel load.
// Enable semantics: m_ei requests one decrement at the next rising edge.
// m_load takes priority over m_ei. eu is a same-cycle borrow out that feeds
// the m_ei input of the next stage. There is no valid/ready backpressure.
// Optional macro B3_DOWN_SAT_EN: saturate at 0000 instead of wrapping to
// 2222. eu still pulses at 0000.
module n4_b3_down_counter
  import b3_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = 8'b00_00_00_00
) (
  input  logic       m_clock,
  input  logic       m_reset_,
  input  logic       m_ei,
  input  logic       m_load,
  input  logic [7:0] m_d,
  output logic       eu,
  output logic       zero,
  output logic [1:0] q01_q00,
  output logic [1:0] q11_q10,
  output logic [1:0] q21_q20,
  output logic [1:0] q31_q30
);

  logic [3:0] digit_zero;
  logic [3:0] digit_en;
  logic       dec_en;
  logic       sat_hold;

`ifdef B3_DOWN_SAT_EN
  // At 0000 a decrement request is absorbed, so the counter stays at zero.
  assign sat_hold = zero;
`else
  assign sat_hold = 1'b0;
`endif

  assign dec_en = m_ei & ~m_load & ~sat_hold;

  // Borrow chain: a digit steps only when every lower digit is at 00.
  always_comb begin
    digit_en    = '0;
    digit_en[0] = dec_en;
    digit_en[1] = dec_en & digit_zero[0];
    digit_en[2] = dec_en & digit_zero[0] & digit_zero[1];
    digit_en[3] = dec_en & digit_zero[0] & digit_zero[1] & digit_zero[2];
  end

  b3_down_digit u_digit0 (
    .clock(m_clock), .reset_(m_reset_), .reset_value(RESET_VALUE[1:0]),
    .load(m_load), .d(m_d[1:0]), .en(digit_en[0]),
    .q(q01_q00), .is_zero(digit_zero[0])
  );

  b3_down_digit u_digit1 (
    .clock(m_clock), .reset_(m_reset_), .reset_value(RESET_VALUE[3:2]),
    .load(m_load), .d(m_d[3:2]), .en(digit_en[1]),
    .q(q11_q10), .is_zero(digit_zero[1])
  );

  b3_down_digit u_digit2 (
    .clock(m_clock), .reset_(m_reset_), .reset_value(RESET_VALUE[5:4]),
    .load(m_load), .d(m_d[5:4]), .en(digit_en[2]),
    .q(q21_q20), .is_zero(digit_zero[2])
  );

  b3_down_digit u_digit3 (
    .clock(m_clock), .reset_(m_reset_), .reset_value(RESET_VALUE[7:6]),
    .load(m_load), .d(m_d[7:6]), .en(digit_en[3]),
    .q(q31_q30), .is_zero(digit_zero[3])
  );

  assign zero = &digit_zero;
  assign eu   = m_ei & ~m_load & zero;

endmodule

// File: tb/tb_n4_b3_down_counter.sv
// Directed testbench for n4_b3_down_counter.
// Expected states come from an integer base-3 model. Define B3_DOWN_SAT_EN
// to check the saturating build.
module tb_n4_b3_down_counter;

  logic       m_clock = 1'b0;
  logic       m_reset_ = 1'b0;
  logic       m_ei = 1'b0;
  logic       m_load = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic       eu;
  logic       zero;
  logic [1:0] q01_q00, q11_q10, q21_q20, q31_q30;
  logic [7:0] state;

  int errors = 0;
  int checks = 0;

  // Clock and reset block.
  always #5 m_clock = ~m_clock;

  n4_b3_down_counter dut (
    .m_clock(m_clock), .m_reset_(m_reset_), .m_ei(m_ei), .m_load(m_load),
    .m_d(m_d), .eu(eu), .zero(zero),
    .q01_q00(q01_q00), .q11_q10(q11_q10), .q21_q20(q21_q20), .q31_q30(q31_q30)
  );

  assign state = {q31_q30, q21_q20, q11_q10, q01_q00};

  // Reference encoding: an integer 0..80 becomes four base-3 digit codes.
  function automatic logic [7:0] enc(input int v);
    logic [7:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[2*i +: 2] = 2'(t % 3);
      t = t / 3;
    end
    return r;
  endfunction

  // Driver: apply inputs on the falling edge, then let them settle.
  task automatic drive(input logic ld, input logic ei, input logic [7:0] d);
    @(negedge m_clock);
    m_load = ld;
    m_ei   = ei;
    m_d    = d;
    #1;
  endtask

  // Advance past one rising edge and sample shortly afterward.
  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  task automatic test_reset();
    #4;
    checks++;
    if (state !== 8'h00 || zero !== 1'b1 || eu !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%b zero=%b eu=%b, need 00000000 1 0", state, zero, eu);
    end
    #6 m_reset_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 8'h00 || zero !== 1'b1 || eu !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: state=%b zero=%b eu=%b, need 00000000 1 0", i, state, zero, eu);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_s;
    logic       exp_z;
`ifdef B3_DOWN_SAT_EN
    exp_s = 8'b00_00_00_00;
    exp_z = 1'b1;
`else
    exp_s = 8'b10_10_10_10;
    exp_z = 1'b0;
`endif
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (eu !== 1'b1) begin
      errors++;
      $display("FAIL wrap_eu: eu=%b, need 1", eu);
    end
    step();
    checks++;
    if (state !== exp_s || zero !== exp_z) begin
      errors++;
      $display("FAIL wrap_state: state=%b zero=%b, need %b %b", state, zero, exp_s, exp_z);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_sweep();
    int model;
    int pulses;
    int pulse_k;
    logic exp_eu;
    drive(1'b1, 1'b0, 8'b10_10_10_10);
    step();
    checks++;
    if (state !== 8'b10_10_10_10) begin
      errors++;
      $display("FAIL sweep_load: state=%b, need 10101010", state);
    end
    model = 80;
    pulses = 0;
    pulse_k = -1;
    for (int k = 0; k <= 80; k++) begin
      drive(1'b0, 1'b1, 8'h00);
      exp_eu = (model == 0);
      checks++;
      if (state !== enc(model) || eu !== exp_eu || zero !== exp_eu) begin
        errors++;
        $display("FAIL sweep_k%0d: state=%b eu=%b zero=%b, need %b %b %b",
                 k, state, eu, zero, enc(model), exp_eu, exp_eu);
      end
      if (eu === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
      step();
`ifdef B3_DOWN_SAT_EN
      model = (model == 0) ? 0 : model - 1;
`else
      model = (model == 0) ? 80 : model - 1;
`endif
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (state !== enc(model)) begin
      errors++;
      $display("FAIL sweep_end: state=%b, need %b", state, enc(model));
    end
    checks++;
    if (pulses !== 1 || pulse_k !== 80) begin
      errors++;
      $display("FAIL sweep_eu_pulse: pulses=%0d at k=%0d, need 1 at k=80", pulses, pulse_k);
    end
  endtask

  task automatic test_borrow();
    drive(1'b1, 1'b0, 8'b01_00_00_00);
    step();
    drive(1'b0, 1'b1, 8'h00);
    step();
    checks++;
    if (state !== 8'b00_10_10_10) begin
      errors++;
      $display("FAIL borrow: state=%b, need 00101010", state);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 1'b1, 8'b11_01_11_00);
    checks++;
    if (eu !== 1'b0) begin
      errors++;
      $display("FAIL load_eu: eu=%b, need 0", eu);
    end
    step();
    checks++;
    if (state !== 8'b10_01_10_00) begin
      errors++;
      $display("FAIL load_coerce: state=%b, need 10011000", state);
    end
    drive(1'b0, 1'b1, 8'h00);
    step();
    checks++;
    if (state !== 8'b10_01_01_10) begin
      errors++;
      $display("FAIL load_then_dec: state=%b, need 10010110", state);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'b01_10_01_10);
    step();
    drive(1'b0, 1'b1, 8'h00);
    step();
    step();
    checks++;
    if (state !== 8'b01_10_01_00) begin
      errors++;
      $display("FAIL count_before_reset: state=%b, need 01100100", state);
    end
    #2;
    m_reset_ = 1'b0;
    m_load   = 1'b1;
    m_d      = 8'b10_10_10_10;
    #1;
    checks++;
    if (state !== 8'h00 || zero !== 1'b1 || eu !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%b zero=%b eu=%b, need 00000000 1 0", state, zero, eu);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (state !== 8'h00) begin
        errors++;
        $display("FAIL reset_held%0d: state=%b, need 00000000", i, state);
      end
    end
    m_load = 1'b0;
    #1;
    checks++;
    if (eu !== 1'b1) begin
      errors++;
      $display("FAIL reset_eu_follows_ei: eu=%b, need 1", eu);
    end
    @(negedge m_clock);
    m_reset_ = 1'b1;
    m_ei = 1'b0;
    step();
    checks++;
    if (state !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL after_release: state=%b zero=%b, need 00000000 1", state, zero);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sweep();
    test_borrow();
    test_load_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n4_b3_down_counter.md
Name: n4_b3_down_counter

Overview:
- Four-digit base-3 down counter with synchronous parallel load.
- Each digit is a 2-bit code: 00, 01 or 10. Code 11 is never stored.
- Counterpart of the team's n4_b3_counter up counter. Used as a reload/countdown timer and as the borrow-side stage in base-3 cascades.
- The eu output chains into the m_ei input of the next stage, the same way the up counter cascades.

Parameters:
- RESET_VALUE, 8'b00_00_00_00, digit pattern loaded on reset. Layout is {d3,d2,d1,d0}. Any 11 digit is coerced to 10.

Ports:
- m_clock  input  1  system clock; all state changes on the rising edge.
- m_reset_  input  1  asynchronous, active-low reset.
- m_ei  input  1  count enable in; decrement by one on the edge when 1.
- m_load  input  1  synchronous parallel load strobe.
- m_d  input  8  load value {d3,d2,d1,d0}, each digit 2 bits.
- eu  output  1  borrow/enable out, combinational.
- zero  output  1  1 when all digits are 00, combinational from state.
- q01_q00  output  2  digit 0 (least significant).
- q11_q10  output  2  digit 1.
- q21_q20  output  2  digit 2.
- q31_q30  output  2  digit 3 (most significant).

Behaviour:
- Reset (m_reset_=0): asynchronous.
  - Digits take RESET_VALUE (coerced) immediately, independent of clock.
  - Default reset state: all digits 00, zero=1, eu=m_ei.
  - Reset released between edges: first state change at the next rising edge.
  - Reset asserted mid-count or mid-load: overrides immediately; a pending load is discarded.
- Priority at each rising edge: m_load, then m_ei, then hold.
- Load (m_load=1):
  - Each digit <= m_d digit, with 11 coerced to 10.
  - m_ei is ignored that cycle, and eu=0 that cycle.
  - Load latency: 1 edge; the new value is visible after that edge.
- Decrement (m_load=0, m_ei=1):
  - Digit 0: 10->01, 01->00, 00->10 (borrow).
  - Digit i>0 changes iff all digits below it are 00; same step rule.
  - Value steps down by one in base 3, e.g. 1000(3) -> 0222(3).
- Hold (m_load=0, m_ei=0): state unchanged.
- Wrap-around: 0000 with m_ei=1 goes to 2222 (10_10_10_10).
- eu = m_ei & ~m_load & zero, combinational, same cycle. It is high exactly on the cycle whose edge causes the wrap; this is the borrow into the next stage.
- zero depends only on state. It is valid one edge after a load or decrement reaches 0000.
- Outputs are glitch-tolerant only at the clock edge. No registered copy of eu.

Optional Feature:
- Macro: B3_DOWN_SAT_EN.
- Defined:
  - At 0000 with m_ei=1 and m_load=0, state holds at 0000 (no wrap).
  - eu is still asserted by the formula above.
  - Load still works normally.
- Undefined: wrap-around to 2222 as above.
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package b3_pkg, containing:
  - Digit constants B3_ZERO=2'b00, B3_ONE=2'b01, B3_TWO=2'b10.
  - Invalid-code constant B3_BAD=2'b11.
  - A coercion function, also reused by the up counter.
- Sub-module b3_down_digit: one digit register with
  - inputs: clock, reset_, reset value, load, d, borrow-in enable;
  - outputs: q, is_zero.
- The top instantiates four b3_down_digit. The borrow chain is AND of m_ei with the lower digits' is_zero.

Test Plan:
- Reset with default RESET_VALUE: m_reset_=0 for 10 time units, then 1 with m_ei=0 -> digits 00_00_00_00, zero=1, eu=0. Hold stable for 5 edges.
- Wrap: from 0000 set m_ei=1 for 1 edge -> eu=1 before the edge, state 10_10_10_10 after, zero=0. With B3_DOWN_SAT_EN defined -> state stays 00_00_00_00.
- Full sweep: load 2222, m_ei=1 for 81 edges -> states descend 80..0, then wrap to 80. eu pulses exactly once, on edge 80 counting from 0. Checked against a reference integer model.
- Multi-digit borrow: load 01_00_00_00 (27), 1 decrement -> 00_10_10_10 (26). All four digits change on one edge.
- Load priority and coercion: m_load=1, m_ei=1, m_d=11_01_11_00 -> state 10_01_10_00 after the edge, eu=0 that cycle. Next edge with m_ei=1 -> 10_01_01_10.
- Async reset mid-count: assert m_reset_=0 between edges while counting from 1212 -> outputs jump to RESET_VALUE before the next edge, with no further change while held low.
